umi_regbank: RTL and testbench



---
 rtl/umi_regbank_pkg.sv | 24 ++
 rtl/umi_regbank_if.sv | 22 ++
 rtl/umi_regbank_cnt.sv | 57 +++++
 rtl/umi_regbank.sv | 127 ++++++++++++
 tb/tb_umi_regbank.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/umi_regbank_pkg.sv
// umi_regbank shared definitions: word offsets, CTRL/STATUS bit
// positions and the default ID value.
package umi_regbank_pkg;

    // Word offsets (reg_addr[7:2])
    localparam logic [5:0] ID           = 6'h00;
    localparam logic [5:0] CTRL         = 6'h01;
    localparam logic [5:0] STATUS       = 6'h02;
    localparam logic [5:0] COUNT        = 6'h03;
    localparam logic [5:0] COMPARE      = 6'h04;
    localparam logic [5:0] SCRATCH_BASE = 6'h08;

    // CTRL bits
    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bits
    localparam int ST_OVF = 0;
    localparam int ST_EVT = 1;
    localparam int ST_CMP = 2;

    localparam logic [31:0] IDVAL_DEF = 32'h554D_4901;

endpackage

// File: rtl/umi_regbank_if.sv
// Simple register port: addr/read/write/wrdata from the master,
// registered rddata back from the slave.
interface umi_regbank_if #(
    parameter int RW = 32,
    parameter int AW = 64
);
    logic [AW-1:0] reg_addr;
    logic          reg_read;
    logic          reg_write;
    logic [RW-1:0] reg_wrdata;
    logic [RW-1:0] reg_rddata;

    modport master (
        output reg_addr, reg_read, reg_write, reg_wrdata,
        input  reg_rddata
    );

    modport slave (
        input  reg_addr, reg_read, reg_write, reg_wrdata,
        output reg_rddata
    );
endinterface

// File: rtl/umi_regbank_cnt.sv
// Loadable free-running counter plus compare register.
// Ports: en_i/load_i/load_val_i drive COUNT, cmp_wr_i/cmp_val_i load
// COMPARE; count_o/compare_o are the register values; wrap_o and
// match_o are this cycle's ovf/cmp set requests.
module umi_regbank_cnt #(
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [RW-1:0] load_val_i,
    input  logic          cmp_wr_i,
    input  logic [RW-1:0] cmp_val_i,
    output logic [RW-1:0] count_o,
    output logic [RW-1:0] compare_o,
    output logic          wrap_o,
    output logic          match_o
);

    logic [RW-1:0] count_q, count_d;
    logic [RW-1:0] compare_q, compare_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + RW'(1);
        end
    end

    always_comb begin
        compare_d = compare_q;
        if (cmp_wr_i) begin
            compare_d = cmp_val_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    // A load replaces the increment, so it cannot wrap.
    assign wrap_o    = en_i & ~load_i & (&count_q);
    // Compares the pre-increment value; a load alone never matches.
    assign match_o   = en_i & (count_q == compare_q);
    assign count_o   = count_q;
    assign compare_o = compare_q;

endmodule

// File: rtl/umi_regbank.sv
// Control/status register bank: ID, CTRL, W1C STATUS, counter with
// compare, scratch words. Ports: clk, reset (async, active high),
// bus (register port slave), event_in (sync event), irq (level).
module umi_regbank
    import umi_regbank_pkg::*;
#(
    parameter int            RW       = 32,
    parameter int            AW       = 64,
    parameter int            NSCRATCH = 8,
    parameter logic [RW-1:0] IDVAL    = RW'(IDVAL_DEF)
) (
    input  logic         clk,
    input  logic         reset,
    umi_regbank_if.slave bus,
    input  logic         event_in,
    output logic         irq
);

    logic [5:0]    off;
    logic [2:0]    sidx;
    logic          sel_id, sel_ctrl, sel_st, sel_cnt, sel_cmp, sel_scr;
    logic          we;

    logic [1:0]    ctrl_q, ctrl_d;
    logic [2:0]    status_q, status_d;
    logic [2:0]    st_set, st_clr;
    logic          evt_q;
    logic          irq_q, irq_d;
    logic [RW-1:0] rddata_q, rd_val;
    logic [RW-1:0] scratch_q [NSCRATCH];

    logic [RW-1:0] count, compare;
    logic          wrap, match;

    // Only the word-select bits take part in decode.
    logic unused_addr;
    assign unused_addr = ^{bus.reg_addr[AW-1:8], bus.reg_addr[1:0]};

    assign off  = bus.reg_addr[7:2];
    assign sidx = off[2:0];
    assign we   = bus.reg_write;

    assign sel_id   = (off == ID);
    assign sel_ctrl = (off == CTRL);
    assign sel_st   = (off == STATUS);
    assign sel_cnt  = (off == COUNT);
    assign sel_cmp  = (off == COMPARE);
    assign sel_scr  = (off[5:3] == SCRATCH_BASE[5:3])
                    && (int'(sidx) < NSCRATCH);

    umi_regbank_cnt #(.RW(RW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .en_i       (ctrl_q[CTRL_CNT_EN]),
        .load_i     (we & sel_cnt),
        .load_val_i (bus.reg_wrdata),
        .cmp_wr_i   (we & sel_cmp),
        .cmp_val_i  (bus.reg_wrdata),
        .count_o    (count),
        .compare_o  (compare),
        .wrap_o     (wrap),
        .match_o    (match)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        if (we && sel_ctrl) begin
            ctrl_d = bus.reg_wrdata[1:0];
        end
    end

    // Hardware sets are OR'ed in after the clear so they win.
    always_comb begin
        st_set         = '0;
        st_set[ST_OVF] = wrap;
        st_set[ST_EVT] = event_in & ~evt_q;
        st_set[ST_CMP] = match;
        st_clr         = (we && sel_st) ? bus.reg_wrdata[2:0] : 3'b000;
        status_d       = (status_q & ~st_clr) | st_set;
        irq_d          = ctrl_d[CTRL_IRQ_EN] & (|status_d);
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_id:   rd_val = IDVAL;
            sel_ctrl: rd_val = RW'(ctrl_q);
            sel_st:   rd_val = RW'(status_q);
            sel_cnt:  rd_val = count;
            sel_cmp:  rd_val = compare;
            sel_scr:  rd_val = scratch_q[sidx];
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            status_q <= '0;
            evt_q    <= 1'b0;
            irq_q    <= 1'b0;
            rddata_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            evt_q    <= event_in;
            irq_q    <= irq_d;
            if (bus.reg_read) begin
                rddata_q <= rd_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (we && sel_scr) begin
            scratch_q[sidx] <= bus.reg_wrdata;
        end
    end

    assign bus.reg_rddata = rddata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_umi_regbank.sv
// Directed bench for umi_regbank: vector table for the register map,
// hand sequences for counter, status, irq and async reset.
module tb_umi_regbank;

    logic clk = 1'b0;
    logic reset;
    logic event_in;
    logic irq;

    int tests = 0;
    int fails = 0;

    umi_regbank_if #(.RW(32), .AW(64)) bus ();

    umi_regbank #(
        .RW       (32),
        .AW       (64),
        .NSCRATCH (8),
        .IDVAL    (32'h554D_4901)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .event_in (event_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [28];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the access edge.
    task automatic access(input logic rd, input logic wr,
                          input logic [63:0] a, input logic [31:0] d,
                          input logic ev);
        bus.reg_read   = rd;
        bus.reg_write  = wr;
        bus.reg_addr   = a;
        bus.reg_wrdata = d;
        event_in       = ev;
        @(negedge clk);
        bus.reg_read  = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [63:0] a,
                         input logic [31:0] exp);
        access(1'b1, 1'b0, a, 32'h0, 1'b0);
        check(nm, bus.reg_rddata, exp);
    endtask

    task automatic wr(input logic [63:0] a, input logic [31:0] d);
        access(1'b0, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 64'h00, 32'h0, 1'b1, 32'h554D4901};
        tbl[1]  = '{1'b1, 1'b0, 64'h04, 32'h0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 64'h08, 32'h0, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 64'h0C, 32'h0, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 64'h10, 32'h0, 1'b1, 32'hFFFFFFFF};
        tbl[5]  = '{1'b1, 1'b0, 64'h20, 32'h0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 64'h2C, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 64'h2C, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 1'b0, 64'h40, 32'h0, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 64'h44, 32'h12345678, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 64'h44, 32'h0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 64'h3C, 32'hA5A5A5A5, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 64'hFFFF_0000_0000_0F3C, 32'h0,
                    1'b1, 32'hA5A5A5A5};
        tbl[13] = '{1'b0, 1'b1, 64'h04, 32'hFFFFFFFC, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 64'h04, 32'h0, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 64'h00, 32'h0, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 64'h00, 32'h0, 1'b1, 32'h554D4901};
        tbl[17] = '{1'b0, 1'b1, 64'h10, 32'h1000, 1'b0, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 64'h10, 32'h0, 1'b1, 32'h1000};
        tbl[19] = '{1'b1, 1'b0, 64'h30, 32'h0, 1'b1, 32'h0};
        tbl[20] = '{1'b0, 1'b1, 64'h0C, 32'h55, 1'b0, 32'h0};
        tbl[21] = '{1'b1, 1'b0, 64'h0C, 32'h0, 1'b1, 32'h55};
        tbl[22] = '{1'b0, 1'b1, 64'h08, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[23] = '{1'b1, 1'b0, 64'h08, 32'h0, 1'b1, 32'h0};
        tbl[24] = '{1'b0, 1'b1, 64'h14, 32'h9, 1'b0, 32'h0};
        tbl[25] = '{1'b1, 1'b0, 64'h14, 32'h0, 1'b1, 32'h0};
        tbl[26] = '{1'b1, 1'b0, 64'h2C, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[27] = '{1'b0, 1'b1, 64'h2C, 32'h0, 1'b0, 32'h0};

        reset          = 1'b1;
        event_in       = 1'b0;
        bus.reg_read   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_addr   = '0;
        bus.reg_wrdata = '0;
        repeat (3) @(negedge clk);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_rddata", bus.reg_rddata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Register map, counter idle
        for (int i = 0; i < 28; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d", i), bus.reg_rddata, tbl[i].exp);
            end
        end
        repeat (2) @(negedge clk);
        check("rddata_hold", bus.reg_rddata, 32'hDEADBEEF);

        // Same-cycle read+write returns pre-write value
        access(1'b1, 1'b1, 64'h04, 32'h1, 1'b0);
        check("rdwr_old", bus.reg_rddata, 32'h0);
        rdchk("rdwr_new", 64'h04, 32'h1);
        wr(64'h04, 32'h0);

        // Wrap: ovf and irq rise on the same edge
        wr(64'h0C, 32'hFFFFFFFE);
        wr(64'h04, 32'h3);
        @(negedge clk);
        check("irq_before_wrap", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_at_wrap", {31'b0, irq}, 32'h1);
        rdchk("count_wrapped", 64'h0C, 32'h0);
        rdchk("status_ovf", 64'h08, 32'h1);
        wr(64'h08, 32'h1);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        // Load overrides increment
        wr(64'h0C, 32'h100);
        rdchk("count_load", 64'h0C, 32'h100);
        rdchk("count_inc", 64'h0C, 32'h101);

        // Compare
        wr(64'h04, 32'h0);
        wr(64'h08, 32'h7);
        wr(64'h10, 32'h10);
        wr(64'h0C, 32'h0C);
        wr(64'h04, 32'h1);
        repeat (3) @(negedge clk);
        rdchk("cmp_early", 64'h08, 32'h0);
        rdchk("cmp_edge", 64'h08, 32'h0);
        rdchk("cmp_set", 64'h08, 32'h4);
        access(1'b0, 1'b1, 64'h08, 32'h4, 1'b1);
        access(1'b1, 1'b0, 64'h08, 32'h0, 1'b0);
        check("w1c_cmp_evt", bus.reg_rddata, 32'h2);
        access(1'b0, 1'b1, 64'h08, 32'h2, 1'b1);
        access(1'b1, 1'b0, 64'h08, 32'h0, 1'b0);
        check("set_wins", bus.reg_rddata, 32'h2);
        access(1'b0, 1'b0, 64'h00, 32'h0, 1'b1);
        access(1'b0, 1'b1, 64'h08, 32'h2, 1'b1);
        access(1'b1, 1'b0, 64'h08, 32'h0, 1'b0);
        check("level_no_evt", bus.reg_rddata, 32'h0);

        // Async reset with irq high and a write in flight
        wr(64'h04, 32'h3);
        access(1'b0, 1'b0, 64'h00, 32'h0, 1'b1);
        access(1'b1, 1'b0, 64'h00, 32'h0, 1'b0);
        check("irq_pre_reset", {31'b0, irq}, 32'h1);
        check("rd_pre_reset", bus.reg_rddata, 32'h554D4901);
        bus.reg_write  = 1'b1;
        bus.reg_addr   = 64'h20;
        bus.reg_wrdata = 32'h1234;
        #2 reset = 1'b1;
        #1;
        check("async_irq", {31'b0, irq}, 32'h0);
        check("async_rddata", bus.reg_rddata, 32'h0);
        @(negedge clk);
        bus.reg_write = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        rdchk("rst_count", 64'h0C, 32'h0);
        rdchk("rst_status", 64'h08, 32'h0);
        rdchk("rst_ctrl", 64'h04, 32'h0);
        rdchk("rst_scratch0", 64'h20, 32'h0);
        rdchk("rst_compare", 64'h10, 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
